// File: rtl/button_input.sv
`default_nettype none
// ============================================================================
// Module   : button_input
// Purpose  : Synchronizes, debounces and edge-detects the eight active-low
//            joypad buttons, and generates the no_push_pwm dimming strobe.
// Revision : 1.0 - initial release
// ============================================================================
module button_input #(
    parameter int DEBOUNCE_CYCLES = 16,
    parameter int PWM_PERIOD      = 256,
    parameter int PWM_DUTY        = 16
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] raw_buttons,
    output logic [7:0] buttons,
    output logic       no_push_pwm,
    output logic       press_pulse
);

    localparam int                   c_cnt_w   = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [c_cnt_w-1:0]   c_cnt_max = c_cnt_w'(DEBOUNCE_CYCLES - 1);
    localparam int                   c_pwm_w   = $clog2(PWM_PERIOD);
    localparam logic [c_pwm_w-1:0]   c_pwm_max = c_pwm_w'(PWM_PERIOD - 1);
    localparam logic [31:0]          c_duty    = PWM_DUTY;

    logic [7:0]         r_sync1;
    logic [7:0]         r_sync2;
    logic [7:0]         w_buttons_next;
    logic [c_pwm_w-1:0] r_pwm_cnt;
    logic               w_pwm_low;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_sync1 <= 8'hFF;
            r_sync2 <= 8'hFF;
        end else begin
            r_sync1 <= raw_buttons;
            r_sync2 <= r_sync1;
        end
    end

    // Each bit owns its counter; a return to the stable level clears it outright.
    for (genvar i = 0; i < 8; i++) begin : g_bit
        logic [c_cnt_w-1:0] r_cnt;
        logic               w_differs;
        logic               w_accept;

        assign w_differs         = (r_sync2[i] != buttons[i]);
        assign w_accept          = w_differs && (r_cnt == c_cnt_max);
        assign w_buttons_next[i] = w_accept ? r_sync2[i] : buttons[i];

        always_ff @(posedge clk) begin
            if (reset || !w_differs || w_accept) begin
                r_cnt <= '0;
            end else begin
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            buttons     <= 8'hFF;
            press_pulse <= 1'b0;
        end else begin
            buttons     <= w_buttons_next;
            press_pulse <= |(buttons & ~w_buttons_next);
        end
    end

    assign w_pwm_low = ({{(32 - c_pwm_w){1'b0}}, r_pwm_cnt} < c_duty);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_pwm_cnt   <= '0;
            no_push_pwm <= 1'b1;
        end else begin
            r_pwm_cnt   <= (r_pwm_cnt == c_pwm_max) ? '0 : r_pwm_cnt + 1'b1;
            no_push_pwm <= !w_pwm_low;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_button_input.sv
`default_nettype none
// ============================================================================
// Module   : tb_button_input
// Purpose  : Directed self-checking bench for button_input.
// Revision : 1.0 - initial release
// ============================================================================
module tb_button_input;

    logic       clk;
    logic       reset;
    logic [7:0] raw_buttons;
    logic [7:0] buttons;
    logic       no_push_pwm;
    logic       press_pulse;
    logic [7:0] buttons_d0;
    logic       pwm_d0;
    logic       press_d0;
    logic [7:0] buttons_d8;
    logic       pwm_d8;
    logic       press_d8;

    int n_checks;
    int n_errors;

    button_input #(.DEBOUNCE_CYCLES(4), .PWM_PERIOD(8), .PWM_DUTY(2)) dut (
        .clk(clk), .reset(reset), .raw_buttons(raw_buttons),
        .buttons(buttons), .no_push_pwm(no_push_pwm), .press_pulse(press_pulse)
    );

    button_input #(.DEBOUNCE_CYCLES(4), .PWM_PERIOD(8), .PWM_DUTY(0)) dut_d0 (
        .clk(clk), .reset(reset), .raw_buttons(raw_buttons),
        .buttons(buttons_d0), .no_push_pwm(pwm_d0), .press_pulse(press_d0)
    );

    button_input #(.DEBOUNCE_CYCLES(4), .PWM_PERIOD(8), .PWM_DUTY(8)) dut_d8 (
        .clk(clk), .reset(reset), .raw_buttons(raw_buttons),
        .buttons(buttons_d8), .no_push_pwm(pwm_d8), .press_pulse(press_d8)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Drive a new level and expect it on buttons after 1+DEBOUNCE_CYCLES edges.
    task automatic step_to(input logic [7:0] prev, input logic [7:0] next, input logic pulse);
        raw_buttons = next;
        for (int j = 0; j < 5; j++) begin
            tick();
            check("step_hold", buttons, prev);
            check("step_nopulse", press_pulse, 1'b0);
        end
        tick();
        check("step_update", buttons, next);
        check("step_pulse", press_pulse, pulse);
        tick();
        check("step_pulse_end", press_pulse, 1'b0);
        check("step_stable", buttons, next);
    endtask

    initial begin
        n_checks    = 0;
        n_errors    = 0;
        reset       = 1'b1;
        raw_buttons = 8'h00;

        for (int j = 0; j < 3; j++) begin
            tick();
            check("rst_buttons", buttons, 8'hFF);
            check("rst_pulse", press_pulse, 1'b0);
            check("rst_pwm", no_push_pwm, 1'b1);
            check("rst_pwm_d8", pwm_d8, 1'b1);
        end

        raw_buttons = 8'hFF;
        reset       = 1'b0;
        for (int j = 0; j < 16; j++) begin
            tick();
            check("pwm_wave", no_push_pwm, ((j % 8) < 2) ? 1'b0 : 1'b1);
            check("pwm_duty0", pwm_d0, 1'b1);
            check("pwm_dutyfull", pwm_d8, 1'b0);
            check("idle_buttons", buttons, 8'hFF);
        end

        step_to(8'hFF, 8'hEF, 1'b1);
        step_to(8'hEF, 8'hFF, 1'b0);

        // Bit 3 bounces: low 3, high 1, then steady low.
        raw_buttons = 8'hF7;
        for (int j = 0; j < 3; j++) begin
            tick();
            check("bounce_hold", buttons, 8'hFF);
        end
        raw_buttons = 8'hFF;
        tick();
        check("bounce_hold", buttons, 8'hFF);
        raw_buttons = 8'hF7;
        for (int j = 0; j < 5; j++) begin
            tick();
            check("bounce_reject", buttons, 8'hFF);
            check("bounce_nopulse", press_pulse, 1'b0);
        end
        tick();
        check("bounce_accept", buttons, 8'hF7);
        check("bounce_pulse", press_pulse, 1'b1);
        tick();
        check("bounce_pulse_end", press_pulse, 1'b0);
        step_to(8'hF7, 8'hFF, 1'b0);

        step_to(8'hFF, 8'h7E, 1'b1);
        step_to(8'h7E, 8'h3F, 1'b1);
        step_to(8'h3F, 8'hFF, 1'b0);

        // Reset lands when bit 5's counter has reached 2.
        raw_buttons = 8'hDF;
        for (int j = 0; j < 4; j++) begin
            tick();
            check("mid_hold", buttons, 8'hFF);
        end
        reset = 1'b1;
        for (int j = 0; j < 2; j++) begin
            tick();
            check("mid_rst_buttons", buttons, 8'hFF);
            check("mid_rst_pulse", press_pulse, 1'b0);
            check("mid_rst_pwm", no_push_pwm, 1'b1);
        end
        reset = 1'b0;
        for (int j = 0; j < 5; j++) begin
            tick();
            check("mid_requalify", buttons, 8'hFF);
        end
        tick();
        check("mid_accept", buttons, 8'hDF);
        check("mid_pulse", press_pulse, 1'b1);
        tick();
        check("mid_pulse_end", press_pulse, 1'b0);
        step_to(8'hDF, 8'hFF, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/button_input.md
# button_input

Front-end conditioning stage for the eight joypad buttons. It synchronizes the raw active-low pin levels, debounces each bit independently, and presents a clean active-low `buttons[7:0]` bitmap. It also generates the `no_push_pwm` dimming signal and a one-cycle press pulse. Its outputs feed the seven-segment button display stage and the joypad register/interrupt logic.

## Interface
- `DEBOUNCE_CYCLES`, 16: consecutive cycles a synchronized level must differ from the stable value before it is accepted; legal range ≥ 1.
- `PWM_PERIOD`, 256: `no_push_pwm` period in clocks; legal range ≥ 2.
- `PWM_DUTY`, 16: clocks per period during which `no_push_pwm` is low; legal range 0..`PWM_PERIOD`.

- `clk` input 1: system clock, the only clock.
- `reset` input 1: synchronous, active-high reset.
- `raw_buttons` input 8: asynchronous pin levels, active-low. Bit map: 0 Right, 1 Left, 2 Up, 3 Down, 4 A, 5 B, 6 Select, 7 Start.
- `buttons` output 8: debounced state, active-low, same bit map.
- `no_push_pwm` output 1: dimming strobe. Low means "light unpressed segments".
- `press_pulse` output 1: one-cycle high when at least one bit of `buttons` went 1→0.

## Operation
- **Synchronizer.** Two flops per bit, `sync1 <= raw_buttons` and `sync2 <= sync1`. Both reset to 8'hFF.
- **Debounce.** Each bit i has a counter `cnt[i]` of width $clog2(DEBOUNCE_CYCLES). Width is at least 1.
  - If `sync2[i] == buttons[i]`, then `cnt[i] <= 0`.
  - Otherwise, if `cnt[i] == DEBOUNCE_CYCLES-1`, then `buttons[i] <= sync2[i]` and `cnt[i] <= 0`.
  - Otherwise, `cnt[i] <= cnt[i] + 1`.
  - Any glitch that returns to the stable level before acceptance clears the counter. No partial credit is kept.
  - Bits are fully independent. Activity on one bit never affects another bit's counter.
- **Press detect.** `press_pulse <= |(buttons & ~buttons_next)`. Here `buttons_next` is the value being written this edge.
  - The pulse is high for exactly the one cycle in which the new `buttons` value is first visible.
  - Releases (0→1) never pulse.
  - Several bits pressing on the same edge give a single one-cycle pulse.
  - A press on one bit and a release on another at the same edge still pulse.
- **PWM.** `pwm_cnt` counts 0..`PWM_PERIOD`-1 and wraps to 0.
  - `no_push_pwm <= !(pwm_cnt < PWM_DUTY)`, registered.
  - `PWM_DUTY` = 0 holds `no_push_pwm` at 1 permanently.
  - `PWM_DUTY` = `PWM_PERIOD` holds it at 0 permanently.

## Timing
- **Reset values:**
  - `buttons` = 8'hFF
  - `press_pulse` = 0
  - `no_push_pwm` = 1
  - `pwm_cnt` = 0
  - all `cnt[i]` = 0
  - `sync1` and `sync2` = 8'hFF
- `reset` overrides every other condition on the same edge. A reset in the middle of a debounce discards the in-progress count. A press held through reset is re-qualified from scratch afterwards, so it takes the full latency again.
- **Debounce latency.** Let `raw_buttons[i]` change and hold before edge k.
  - `sync1` captures it at edge k.
  - `sync2` captures it at edge k+1.
  - `buttons[i]` changes at edge k+1+`DEBOUNCE_CYCLES`.
  - `press_pulse` is high from edge k+1+`DEBOUNCE_CYCLES` to edge k+2+`DEBOUNCE_CYCLES`.
- **Glitch rejection.** A deviation that lasts N ≤ `DEBOUNCE_CYCLES`-1 cycles at `sync2` is rejected.
- **PWM timing.** The first reset-release edge samples `pwm_cnt` = 0. `no_push_pwm` therefore goes low one cycle after reset deasserts when `PWM_DUTY` ≥ 1. It stays low for `PWM_DUTY` cycles of every `PWM_PERIOD`-cycle period.
- There is no handshake. All outputs are registered.

## Test plan
- **Reset defaults.** Assert `reset` with arbitrary `raw_buttons`, e.g. 8'h00. Expect `buttons` = 8'hFF, `press_pulse` = 0, `no_push_pwm` = 1 throughout reset.
- **Clean press and release.** `DEBOUNCE_CYCLES` = 4.
  - Drive `raw_buttons` = 8'hEF (A) before edge k. Expect `buttons` = 8'hEF exactly after edge k+5, and `press_pulse` high for that one cycle only.
  - Release to 8'hFF. Expect `buttons` = 8'hFF 5 edges later and no pulse.
- **Bounce rejection.** `DEBOUNCE_CYCLES` = 4.
  - Toggle bit 3 low for 3 cycles, high for 1 cycle, then low steadily.
  - Expect no change during the bounce.
  - Expect `buttons[3]` = 0 only after 4 consecutive low `sync2` cycles, i.e. 5 edges after the final steady low reaches `sync1`.
- **Simultaneous multi-bit activity.**
  - Step 8'hFF → 8'h7E (Start and Right) on one edge. Expect both bits to update on the same edge and a single one-cycle pulse.
  - Then drive bit 0 release together with bit 6 press on one edge. Expect one pulse.
- **PWM waveform.** `PWM_PERIOD` = 8, `PWM_DUTY` = 2.
  - Expect `no_push_pwm` pattern 0,0,1,1,1,1,1,1 repeating, starting one cycle after reset release.
  - `PWM_DUTY` = 0 gives constant 1. `PWM_DUTY` = 8 gives constant 0.
- **Reset mid-debounce.**
  - Hold bit 5 low. Assert `reset` when `cnt[5]` = 2.
  - Expect `buttons` to stay 8'hFF.
  - After release, `buttons[5]` falls a full 1+`DEBOUNCE_CYCLES` edges after `sync1` sees the low again.
